// File: rtl/reg_file_pkg.sv
// Shared defaults, types and address-qualification helper for the multiport register file.
package reg_file_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_NUM_REGS = 16;
    localparam int unsigned DEF_NUM_RD   = 2;
    localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_ADDR_W-1:0] rf_addr_t;
    typedef logic [DEF_DATA_W-1:0] rf_data_t;

    // True when addr names a real register that accepts writes and reservations.
    function automatic logic rfWritable(int unsigned addr, int unsigned numRegs, bit zeroReg);
        return (addr < numRegs) && !(zeroReg && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending flags: set by a reservation, cleared by the producer's write.
module rf_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned  NUM_REGS = DEF_NUM_REGS,
    parameter bit           ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                rsv_en,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busyQ;
    logic [NUM_REGS-1:0] busyD;

    always_comb begin
        busyD = busyQ;
        if (wr_en && rfWritable(32'(wr_addr), NUM_REGS, ZERO_REG)) begin
            busyD[wr_addr] = 1'b0;
        end
        // Applied after the clear so a same-cycle reservation opens a new pending window.
        if (rsv_en && rfWritable(32'(rsv_addr), NUM_REGS, ZERO_REG)) begin
            busyD[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyQ <= '0;
        end else begin
            busyQ <= busyD;
        end
    end

    assign busy_vec = busyQ;

endmodule

// File: rtl/multiport_reg_file.sv
// Multiport register file with combinational read ports and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module multiport_reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned  DATA_W   = DEF_DATA_W,
    parameter int unsigned  NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned  NUM_RD   = DEF_NUM_RD,
    parameter bit           ZERO_REG = 1'b1,
    localparam int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic [NUM_RD-1:0]              rd_ready,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           rsv_en,
    input  logic [ADDR_W-1:0]              rsv_addr,
    output logic [NUM_REGS-1:0]            busy_vec
);

    logic [DATA_W-1:0] regsQ [NUM_REGS];
    logic              wrTake;

    assign wrTake = wr_en && rfWritable(32'(wr_addr), NUM_REGS, ZERO_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regsQ[i] <= '0;
            end
        end else if (wrTake) begin
            regsQ[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG)
    ) uScoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    // Unwritable addresses (out of range, hardwired zero) read as a ready zero.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p]  = '0;
            rd_ready[p] = 1'b1;
            if (rfWritable(32'(rd_addr[p]), NUM_REGS, ZERO_REG)) begin
                rd_data[p]  = regsQ[rd_addr[p]];
                rd_ready[p] = ~busy_vec[rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
                // Gated by rst_n so reset forces zero reads even while wr_en is held.
                if (rst_n && wr_en && (wr_addr == rd_addr[p])) begin
                    rd_data[p]  = wr_data;
                    rd_ready[p] = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Bench for multiport_reg_file: a default instance and a 12x32, 4-port instance, checked
// against an array model of the register/pending rules.
module tb_multiport_reg_file;
    import reg_file_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][3:0]  aRdAddr;
    logic [1:0][15:0] aRdData;
    logic [1:0]       aRdReady;
    logic             aWrEn;
    logic             aRsvEn;
    rf_addr_t         aWrAddr;
    rf_addr_t         aRsvAddr;
    rf_data_t         aWrData;
    logic [15:0]      aBusy;

    logic [3:0][3:0]  bRdAddr;
    logic [3:0][31:0] bRdData;
    logic [3:0]       bRdReady;
    logic             bWrEn;
    logic             bRsvEn;
    logic [3:0]       bWrAddr;
    logic [3:0]       bRsvAddr;
    logic [31:0]      bWrData;
    logic [11:0]      bBusy;

    int checks = 0;
    int passes = 0;

    logic [31:0] mem  [2][16];
    logic        pend [2][16];

    multiport_reg_file dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (aRdAddr),
        .rd_data  (aRdData),
        .rd_ready (aRdReady),
        .wr_en    (aWrEn),
        .wr_addr  (aWrAddr),
        .wr_data  (aWrData),
        .rsv_en   (aRsvEn),
        .rsv_addr (aRsvAddr),
        .busy_vec (aBusy)
    );

    multiport_reg_file #(
        .DATA_W   (32),
        .NUM_REGS (12),
        .NUM_RD   (4)
    ) dutB (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (bRdAddr),
        .rd_data  (bRdData),
        .rd_ready (bRdReady),
        .wr_en    (bWrEn),
        .wr_addr  (bWrAddr),
        .wr_data  (bWrData),
        .rsv_en   (bRsvEn),
        .rsv_addr (bRsvAddr),
        .busy_vec (bBusy)
    );

    function automatic int unsigned nRegs(int d);
        return (d == 0) ? 16 : 12;
    endfunction

    function automatic bit usable(int d, int unsigned a);
        return (a != 0) && (a < nRegs(d));
    endfunction

    function automatic logic [31:0] expData(int d, int unsigned a, logic we, int unsigned wa,
                                            logic [31:0] wd);
        if (!usable(d, a)) return '0;
        if (Bypass && we && (wa == a)) return wd;
        return mem[d][a];
    endfunction

    function automatic logic expReady(int d, int unsigned a, logic we, int unsigned wa);
        if (!usable(d, a)) return 1'b1;
        if (Bypass && we && (wa == a)) return 1'b1;
        return !pend[d][a];
    endfunction

    function automatic void modelClear();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 16; a++) begin
                mem[d][a]  = '0;
                pend[d][a] = 1'b0;
            end
        end
    endfunction

    function automatic void modelEdge(int d, logic we, int unsigned wa, logic [31:0] wd,
                                      logic re, int unsigned ra);
        if (we && usable(d, wa)) begin
            mem[d][wa]  = wd;
            pend[d][wa] = 1'b0;
        end
        if (re && usable(d, ra)) pend[d][ra] = 1'b1;
    endfunction

    task automatic step();
        if (rst_n) begin
            modelEdge(0, aWrEn, 32'(aWrAddr), 32'(aWrData), aRsvEn, 32'(aRsvAddr));
            modelEdge(1, bWrEn, 32'(bWrAddr), bWrData, bRsvEn, 32'(bRsvAddr));
        end else begin
            modelClear();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        aWrEn  = 1'b0;
        aRsvEn = 1'b0;
        bWrEn  = 1'b0;
        bRsvEn = 1'b0;
    endtask

    task automatic test_reset();
        aWrEn = 1'b1; aWrAddr = 4'd5; aWrData = 16'hFFFF; aRsvEn = 1'b1; aRsvAddr = 4'd6;
        bWrEn = 1'b1; bWrAddr = 4'd5; bWrData = '1;       bRsvEn = 1'b1; bRsvAddr = 4'd6;
        #3 rst_n = 1'b0;
        modelClear();
        step();
        step();
        for (int a = 0; a < 16; a++) begin
            aRdAddr[0] = 4'(a);
            aRdAddr[1] = 4'(15 - a);
            bRdAddr    = {4{4'(a)}};
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (aRdData[p] !== 16'h0000 || aRdReady[p] !== 1'b1)
                    $display("FAIL reset_read_a p%0d a%0d: got %h/%b, want 0000/1",
                             p, aRdAddr[p], aRdData[p], aRdReady[p]);
                else passes++;
            end
            for (int p = 0; p < 4; p++) begin
                checks++;
                if (bRdData[p] !== 32'h0 || bRdReady[p] !== 1'b1)
                    $display("FAIL reset_read_b p%0d a%0d: got %h/%b, want 0/1",
                             p, a, bRdData[p], bRdReady[p]);
                else passes++;
            end
        end
        checks++;
        if (aBusy !== 16'h0000 || bBusy !== 12'h000)
            $display("FAIL reset_busy: got %h/%h, want 0000/000", aBusy, bBusy);
        else passes++;
        idle();
        rst_n = 1'b1;
        step();
        // Reset asserted mid-cycle while a write and reservation are being driven.
        aWrEn = 1'b1; aWrAddr = 4'd5; aWrData = 16'h1234;
        step();
        aWrEn = 1'b0; aRdAddr[0] = 4'd5;
        #1;
        checks++;
        if (aRdData[0] !== 16'h1234)
            $display("FAIL prereset_write: got %h, want 1234", aRdData[0]);
        else passes++;
        aWrEn = 1'b1; aWrData = 16'hFFFF; aRsvEn = 1'b1; aRsvAddr = 4'd5;
        #2 rst_n = 1'b0;
        modelClear();
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (aRdData[0] !== 16'h0000 || aRdReady[0] !== 1'b1 || aBusy !== 16'h0000)
                $display("FAIL midwrite_reset%0d: got %h/%b/%h, want 0000/1/0000",
                         k, aRdData[0], aRdReady[0], aBusy);
            else passes++;
            step();
        end
        idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        aWrEn = 1'b1; aWrAddr = 4'd5; aWrData = 16'hBEEF;
        step();
        idle();
        aRdAddr[0] = 4'd5; aRdAddr[1] = 4'd5;
        #1;
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (aRdData[p] !== 16'hBEEF || aRdReady[p] !== 1'b1)
                $display("FAIL write_read p%0d: got %h/%b, want beef/1",
                         p, aRdData[p], aRdReady[p]);
            else passes++;
        end
    endtask

    task automatic test_scoreboard();
        aRsvEn = 1'b1; aRsvAddr = 4'd3;
        step();
        idle();
        aRdAddr[0] = 4'd3;
        #1;
        checks++;
        if (aBusy !== 16'h0008 || aRdReady[0] !== 1'b0)
            $display("FAIL reserve: got %h/%b, want 0008/0", aBusy, aRdReady[0]);
        else passes++;
        aWrEn = 1'b1; aWrAddr = 4'd3; aWrData = 16'h1234;
        step();
        idle();
        #1;
        checks++;
        if (aBusy !== 16'h0000 || aRdData[0] !== 16'h1234 || aRdReady[0] !== 1'b1)
            $display("FAIL write_clears: got %h/%h/%b, want 0000/1234/1",
                     aBusy, aRdData[0], aRdReady[0]);
        else passes++;
        aWrEn = 1'b1; aWrAddr = 4'd3; aWrData = 16'h1234; aRsvEn = 1'b1; aRsvAddr = 4'd3;
        step();
        idle();
        #1;
        checks++;
        if (aRdData[0] !== 16'h1234 || aBusy[3] !== 1'b1 || aRdReady[0] !== 1'b0)
            $display("FAIL rsv_and_write: got %h/%b/%b, want 1234/1/0",
                     aRdData[0], aBusy[3], aRdReady[0]);
        else passes++;
        aRsvEn = 1'b1; aRsvAddr = 4'd3;
        step();
        idle();
        #1;
        checks++;
        if (aBusy !== 16'h0008)
            $display("FAIL rereserve: got %h, want 0008", aBusy);
        else passes++;
        aWrEn = 1'b1; aWrAddr = 4'd3; aWrData = 16'h1234;
        step();
        idle();
    endtask

    task automatic test_zero_reg();
        aWrEn = 1'b1; aWrAddr = 4'd0; aWrData = 16'hAAAA; aRsvEn = 1'b1; aRsvAddr = 4'd0;
        aRdAddr[0] = 4'd0;
        #1;
        checks++;
        if (aRdData[0] !== 16'h0000 || aRdReady[0] !== 1'b1)
            $display("FAIL zero_during_write: got %h/%b, want 0000/1", aRdData[0], aRdReady[0]);
        else passes++;
        step();
        idle();
        #1;
        checks++;
        if (aRdData[0] !== 16'h0000 || aRdReady[0] !== 1'b1 || aBusy[0] !== 1'b0)
            $display("FAIL zero_after: got %h/%b/%b, want 0000/1/0",
                     aRdData[0], aRdReady[0], aBusy[0]);
        else passes++;
    endtask

    task automatic test_bypass();
        aWrEn = 1'b1; aWrAddr = 4'd7; aWrData = 16'h1111;
        step();
        idle();
        aRsvEn = 1'b1; aRsvAddr = 4'd7;
        step();
        idle();
        aWrEn = 1'b1; aWrAddr = 4'd7; aWrData = 16'h5A5A;
        aRdAddr[0] = 4'd7; aRdAddr[1] = 4'd5;
        #1;
        checks++;
        if (aRdData[0] !== (Bypass ? 16'h5A5A : 16'h1111) || aRdReady[0] !== Bypass)
            $display("FAIL bypass_same_cycle: got %h/%b, want %h/%b", aRdData[0], aRdReady[0],
                     Bypass ? 16'h5A5A : 16'h1111, Bypass);
        else passes++;
        checks++;
        if (aRdData[1] !== 16'hBEEF)
            $display("FAIL bypass_other_port: got %h, want beef", aRdData[1]);
        else passes++;
        step();
        idle();
        #1;
        checks++;
        if (aRdData[0] !== 16'h5A5A || aRdReady[0] !== 1'b1)
            $display("FAIL bypass_next_cycle: got %h/%b, want 5a5a/1", aRdData[0], aRdReady[0]);
        else passes++;
    endtask

    task automatic test_sweep();
        logic [31:0] vals [12];
        logic [31:0] want;
        for (int r = 0; r < 12; r++) begin
            vals[r] = $urandom;
            bWrEn = 1'b1; bWrAddr = 4'(r); bWrData = vals[r];
            step();
        end
        idle();
        for (int pass = 0; pass < 2; pass++) begin
            for (int g = 0; g < 12; g += 4) begin
                for (int p = 0; p < 4; p++) bRdAddr[p] = 4'(g + p);
                #1;
                for (int p = 0; p < 4; p++) begin
                    want = (g + p == 0) ? 32'h0 : vals[g + p];
                    checks++;
                    if (bRdData[p] !== want || bRdReady[p] !== 1'b1)
                        $display("FAIL sweep%0d r%0d: got %h/%b, want %h/1",
                                 pass, g + p, bRdData[p], bRdReady[p], want);
                    else passes++;
                end
            end
            if (pass == 0) begin
                bRdAddr = {4{4'd13}};
                #1;
                for (int p = 0; p < 4; p++) begin
                    checks++;
                    if (bRdData[p] !== 32'h0 || bRdReady[p] !== 1'b1)
                        $display("FAIL oob_read p%0d: got %h/%b, want 0/1",
                                 p, bRdData[p], bRdReady[p]);
                    else passes++;
                end
                bWrEn = 1'b1; bWrAddr = 4'd13; bWrData = '1; bRsvEn = 1'b1; bRsvAddr = 4'd13;
                step();
                idle();
            end
        end
        checks++;
        if (bBusy !== 12'h000)
            $display("FAIL oob_busy: got %h, want 000", bBusy);
        else passes++;
    endtask

    task automatic test_random();
        logic [31:0] ed;
        logic [15:0] eba;
        logic [11:0] ebb;
        for (int n = 0; n < 400; n++) begin
            aWrEn    = 1'($urandom_range(0, 1));
            aWrAddr  = 4'($urandom);
            aWrData  = 16'($urandom);
            aRsvEn   = ($urandom_range(0, 3) == 0);
            aRsvAddr = 4'($urandom);
            for (int p = 0; p < 2; p++)
                aRdAddr[p] = ($urandom_range(0, 3) == 0) ? aWrAddr : 4'($urandom);
            bWrEn    = 1'($urandom_range(0, 1));
            bWrAddr  = 4'($urandom);
            bWrData  = $urandom;
            bRsvEn   = ($urandom_range(0, 3) == 0);
            bRsvAddr = 4'($urandom);
            for (int p = 0; p < 4; p++)
                bRdAddr[p] = ($urandom_range(0, 3) == 0) ? bWrAddr : 4'($urandom);
            #1;
            for (int p = 0; p < 2; p++) begin
                ed = expData(0, 32'(aRdAddr[p]), aWrEn, 32'(aWrAddr), 32'(aWrData));
                checks++;
                if (aRdData[p] !== ed[15:0] ||
                    aRdReady[p] !== expReady(0, 32'(aRdAddr[p]), aWrEn, 32'(aWrAddr)))
                    $display("FAIL rand_a n%0d p%0d a%0d: got %h/%b, want %h/%b", n, p,
                             aRdAddr[p], aRdData[p], aRdReady[p], ed[15:0],
                             expReady(0, 32'(aRdAddr[p]), aWrEn, 32'(aWrAddr)));
                else passes++;
            end
            for (int p = 0; p < 4; p++) begin
                ed = expData(1, 32'(bRdAddr[p]), bWrEn, 32'(bWrAddr), bWrData);
                checks++;
                if (bRdData[p] !== ed ||
                    bRdReady[p] !== expReady(1, 32'(bRdAddr[p]), bWrEn, 32'(bWrAddr)))
                    $display("FAIL rand_b n%0d p%0d a%0d: got %h/%b, want %h/%b", n, p,
                             bRdAddr[p], bRdData[p], bRdReady[p], ed,
                             expReady(1, 32'(bRdAddr[p]), bWrEn, 32'(bWrAddr)));
                else passes++;
            end
            for (int a = 0; a < 16; a++) eba[a] = pend[0][a];
            for (int a = 0; a < 12; a++) ebb[a] = pend[1][a];
            checks++;
            if (aBusy !== eba || bBusy !== ebb)
                $display("FAIL rand_busy n%0d: got %h/%h, want %h/%h", n, aBusy, bBusy, eba, ebb);
            else passes++;
            step();
        end
        idle();
    endtask

    initial begin
        aRdAddr = '0; aWrEn = 1'b0; aWrAddr = '0; aWrData = '0; aRsvEn = 1'b0; aRsvAddr = '0;
        bRdAddr = '0; bWrEn = 1'b0; bWrAddr = '0; bWrData = '0; bRsvEn = 1'b0; bRsvAddr = '0;
        modelClear();
        test_reset();
        test_write_read();
        test_scoreboard();
        test_zero_reg();
        test_bypass();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
